// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep sequencer: FSM states, comparator
// encodings and default parameter values.
package sweep_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHArm,
        StHSweep,
        StHSettle,
        StVArm,
        StVSweep,
        StVSettle,
        StFinish
    } sweep_state_e;

    // Comparator encodings; 2'b11 is treated as balanced as well.
    localparam logic [1:0] CMP_BAL = 2'b00;
    localparam logic [1:0] CMP_NEG = 2'b01;
    localparam logic [1:0] CMP_POS = 2'b10;

    localparam int unsigned STEP_DIV_DEF    = 4;
    localparam int unsigned ARM_TIMEOUT_DEF = 8;
    localparam int unsigned PASSES_DEF      = 1;

    // Map a comparator value to a {neg, pos} step request; at most one bit set.
    function automatic logic [1:0] cmp_dir(input logic [1:0] cmp);
        return {cmp == CMP_NEG, cmp == CMP_POS};
    endfunction

endpackage

// File: rtl/step_divider.sv
// Step divider: tick on the first cycle after restart drops, then every
// STEP_DIV cycles while restart stays low.
module step_divider
    import sweep_pkg::*;
#(
    parameter int unsigned STEP_DIV = STEP_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

    logic [7:0] cnt_q, cnt_d;

    // Next count: held at zero by restart, otherwise cycles 0..STEP_DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = 8'd0;
        end else if (cnt_q >= LAST) begin
            cnt_d = 8'd0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign tick = !restart && (cnt_q == 8'd0);

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sweep_sequencer.sv
// Sweep sequencer: runs PASSES rounds of horizontal then vertical servo sweeps,
// arming each counter, stepping the servo from the light comparator on divider
// ticks, and reporting BUSY/DONE/ERR.
// Optional feature: define SWEEP_AUTO_RESTART_EN to restart from FINISH while
// START is still high.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int unsigned STEP_DIV    = STEP_DIV_DEF,
    parameter int unsigned ARM_TIMEOUT = ARM_TIMEOUT_DEF,
    parameter int unsigned PASSES      = PASSES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cnt_l,
    input  logic       cnt_v,
    input  logic [1:0] cmp_h,
    input  logic [1:0] cmp_v,
    output logic       hs,
    output logic       vs,
    output logic       step_l,
    output logic       step_r,
    output logic       step_u,
    output logic       step_d,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned TMR_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ARM_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [3:0]       PASS_INIT = 4'(PASSES);

    sweep_state_e     state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       pass_q, pass_d;
    logic             err_q, err_d;
    logic             start_q;
    // Low until the first clock after reset so a START held across reset
    // release is not taken as an edge.
    logic             armed_q;
    logic             arm_fail;
    logic             start_edge;
    logic             div_restart;
    logic             div_tick;

    assign start_edge  = armed_q && start && !start_q;
    assign div_restart = !((state_q == StHSweep) || (state_q == StVSweep));

    step_divider #(
        .STEP_DIV (STEP_DIV)
    ) u_step_divider (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (div_restart),
        .tick    (div_tick)
    );

    // Next-state and output decode.
    always_comb begin
        state_d  = state_q;
        tmr_d    = '0;
        pass_d   = pass_q;
        err_d    = err_q;
        hs       = 1'b0;
        vs       = 1'b0;
        step_l   = 1'b0;
        step_r   = 1'b0;
        step_u   = 1'b0;
        step_d   = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        arm_fail = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (start_edge) begin
                    state_d = StHArm;
                    pass_d  = PASS_INIT;
                    err_d   = 1'b0;
                end
            end
            StHArm: begin
                hs = 1'b1;
                if (cnt_l) begin
                    state_d = StHSweep;
                end else if (tmr_q == TMR_LAST) begin
                    arm_fail = 1'b1;
                    err_d    = 1'b1;
                    state_d  = StIdle;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            StHSweep: begin
                hs = 1'b1;
                // Terminal count wins over a tick landing in the same cycle.
                if (!cnt_l) begin
                    state_d = StHSettle;
                end else if (div_tick) begin
                    {step_l, step_r} = cmp_dir(cmp_h);
                end
            end
            StHSettle: begin
                state_d = StVArm;
            end
            StVArm: begin
                vs = 1'b1;
                if (cnt_v) begin
                    state_d = StVSweep;
                end else if (tmr_q == TMR_LAST) begin
                    arm_fail = 1'b1;
                    err_d    = 1'b1;
                    state_d  = StIdle;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            StVSweep: begin
                vs = 1'b1;
                if (!cnt_v) begin
                    state_d = StVSettle;
                end else if (div_tick) begin
                    {step_u, step_d} = cmp_dir(cmp_v);
                end
            end
            StVSettle: begin
                pass_d  = pass_q - 4'd1;
                state_d = (pass_q == 4'd1) ? StFinish : StHArm;
            end
            StFinish: begin
                done = 1'b1;
`ifdef SWEEP_AUTO_RESTART_EN
                if (start) begin
                    state_d = StHArm;
                    pass_d  = PASS_INIT;
                end else begin
                    state_d = StIdle;
                end
`else
                state_d = StIdle;
`endif
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ERR rises in the failing arm cycle itself, then holds from the register.
    assign err = err_q | arm_fail;

    // State, counters and START edge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tmr_q   <= '0;
            pass_q  <= 4'd0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            start_q <= start;
            armed_q <= 1'b1;
        end
    end

endmodule
